// File: rtl/sum_loop_ctrl_if.sv
// sum_loop_ctrl_if: handshake and DataPath control bundle between the system and sum_loop_ctrl
interface sum_loop_ctrl_if #(
    parameter int ITER_W = 8
);
    logic              start;
    logic              abort;
    logic              ILe10;
    logic              SumSrcMuxSel;
    logic              ISrcMuxSel;
    logic              SumEn;
    logic              IEn;
    logic              AdderSrcMuxSel;
    logic              OutPortEn;
    logic              busy;
    logic              done;
    logic              err;
    logic [ITER_W-1:0] iter_cnt;
    modport master (
        output start, abort, ILe10,
        input  SumSrcMuxSel, ISrcMuxSel, SumEn, IEn, AdderSrcMuxSel, OutPortEn, busy, done, err, iter_cnt
    );
    modport slave (
        input  start, abort, ILe10,
        output SumSrcMuxSel, ISrcMuxSel, SumEn, IEn, AdderSrcMuxSel, OutPortEn, busy, done, err, iter_cnt
    );
endinterface

// File: rtl/sum_loop_ctrl.sv
// sum_loop_ctrl: Moore controller sequencing the DataPath accumulation 0+1+..+10,
// with start/busy/done handshake, synchronous abort and an iteration watchdog
module sum_loop_ctrl #(
    parameter int ITER_W   = 8,
    parameter int MAX_ITER = 16
) (
    input logic            clk,
    input logic            reset,
    sum_loop_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_CMP, S_SUM, S_INC, S_OUT, S_DONE
    } state_t;
    localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(MAX_ITER);
    state_t            state_q, state_d;
    logic [ITER_W-1:0] iter_cnt_q, iter_cnt_d;
    logic              err_q, err_d;
    logic              sum_sel_q, sum_sel_d, i_sel_q, i_sel_d, add_sel_q, add_sel_d;
    logic              sum_en_q, sum_en_d, i_en_q, i_en_d, out_en_q, out_en_d;
    logic              busy_q, busy_d, done_q, done_d;
    always_comb begin
        state_d    = state_q;
        iter_cnt_d = iter_cnt_q;
        err_d      = err_q;
        if (state_q != S_IDLE && bus.abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: state_d = (bus.start && !bus.abort) ? S_INIT : S_IDLE;
                S_INIT: begin
                    iter_cnt_d = '0;
                    err_d      = 1'b0;
                    state_d    = S_CMP;
                end
                S_CMP: begin
                    state_d = !bus.ILe10 ? S_OUT : (iter_cnt_q < ITER_MAX) ? S_SUM : S_DONE;
                    err_d   = err_q | (bus.ILe10 && iter_cnt_q >= ITER_MAX);
                end
                S_SUM: state_d = S_INC;
                S_INC: begin
                    iter_cnt_d = (iter_cnt_q >= ITER_MAX) ? iter_cnt_q : iter_cnt_q + 1'b1;
                    state_d    = S_CMP;
                end
                S_OUT:   state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
        // outputs are registered from the next-state decode so each one is a pure function of state_q
        sum_en_d  = state_d == S_INIT || state_d == S_SUM;
        i_en_d    = state_d == S_INIT || state_d == S_INC;
        sum_sel_d = state_d == S_SUM;
        i_sel_d   = state_d == S_INC;
        add_sel_d = state_d == S_INC;
        out_en_d  = state_d == S_OUT;
        busy_d    = state_d != S_IDLE;
        done_d    = state_d == S_DONE;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            iter_cnt_q <= '0;
            err_q      <= 1'b0;
            sum_en_q   <= 1'b0;
            i_en_q     <= 1'b0;
            sum_sel_q  <= 1'b0;
            i_sel_q    <= 1'b0;
            add_sel_q  <= 1'b0;
            out_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            iter_cnt_q <= iter_cnt_d;
            err_q      <= err_d;
            sum_en_q   <= sum_en_d;
            i_en_q     <= i_en_d;
            sum_sel_q  <= sum_sel_d;
            i_sel_q    <= i_sel_d;
            add_sel_q  <= add_sel_d;
            out_en_q   <= out_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end
    assign bus.SumEn          = sum_en_q;
    assign bus.IEn            = i_en_q;
    assign bus.SumSrcMuxSel   = sum_sel_q;
    assign bus.ISrcMuxSel     = i_sel_q;
    assign bus.AdderSrcMuxSel = add_sel_q;
    assign bus.OutPortEn      = out_en_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.err            = err_q;
    assign bus.iter_cnt       = iter_cnt_q;
endmodule

// File: tb/tb_sum_loop_ctrl.sv
// tb_sum_loop_ctrl: drives sum_loop_ctrl beside a behavioural DataPath; one instance with the
// default watchdog and one with MAX_ITER=5 so the watchdog exit is reachable
module tb_sum_loop_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;
    sum_loop_ctrl_if #(.ITER_W(8)) m_if ();
    sum_loop_ctrl_if #(.ITER_W(8)) w_if ();
    sum_loop_ctrl #(.ITER_W(8), .MAX_ITER(16)) u_dut (.clk(clk), .reset(reset), .bus(m_if.slave));
    sum_loop_ctrl #(.ITER_W(8), .MAX_ITER(5))  u_wd  (.clk(clk), .reset(reset), .bus(w_if.slave));
    logic [7:0] m_sum, m_i, m_out, m_add, w_sum, w_i, w_out, w_add;
    assign m_add = m_if.AdderSrcMuxSel ? m_i + 8'd1 : m_sum + m_i;
    assign w_add = w_if.AdderSrcMuxSel ? w_i + 8'd1 : w_sum + w_i;
    assign m_if.ILe10 = m_i <= 8'd10;
    assign w_if.ILe10 = w_i <= 8'd10;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_sum <= '0; m_i <= '0; m_out <= '0;
            w_sum <= '0; w_i <= '0; w_out <= '0;
        end else begin
            if (m_if.SumEn)     m_sum <= m_if.SumSrcMuxSel ? m_add : 8'd0;
            if (m_if.IEn)       m_i   <= m_if.ISrcMuxSel ? m_add : 8'd0;
            if (m_if.OutPortEn) m_out <= m_sum;
            if (w_if.SumEn)     w_sum <= w_if.SumSrcMuxSel ? w_add : 8'd0;
            if (w_if.IEn)       w_i   <= w_if.ISrcMuxSel ? w_add : 8'd0;
            if (w_if.OutPortEn) w_out <= w_sum;
        end
    end
    typedef struct {
        int abort_at;
        int restart_at;
        int done_at;
        int exp_iter;
        int exp_err;
        int exp_out;
    } vec_t;
    typedef struct {
        int out;
        int iter;
        int err;
    } exp_t;
    vec_t vecs[5];
    exp_t sb[$];
    int n_pass = 0;
    int n_tot = 0;
    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask
    function automatic int m_ctrl();
        return int'({m_if.SumEn, m_if.IEn, m_if.SumSrcMuxSel, m_if.ISrcMuxSel,
                     m_if.AdderSrcMuxSel, m_if.OutPortEn, m_if.busy, m_if.done, m_if.err});
    endfunction
    // enters and leaves on a falling edge; cycle j is the falling edge after accept edge k+j
    task automatic run_vec(input vec_t v, input int idx);
        bit seen = 0;
        bit oen = 0;
        exp_t e;
        m_if.start = 1'b1;
        if (v.done_at >= 0) sb.push_back('{v.exp_out, v.exp_iter, v.exp_err});
        @(negedge clk);
        m_if.start = 1'b0;
        chk($sformatf("v%0d busy_after_start", idx), int'(m_if.busy), 1);
        for (int j = 0; j < 60; j++) begin
            m_if.start = (j == v.restart_at);
            m_if.abort = (j == v.abort_at);
            if (m_if.OutPortEn) oen = 1;
            if (m_if.done) begin
                seen = 1;
                chk($sformatf("v%0d done_cycle", idx), j, v.done_at);
                if (sb.size() == 0) chk($sformatf("v%0d sb_nonempty", idx), 0, 1);
                else begin
                    e = sb.pop_front();
                    chk($sformatf("v%0d outport", idx), int'(m_out), e.out);
                    chk($sformatf("v%0d iter_cnt", idx), int'(m_if.iter_cnt), e.iter);
                    chk($sformatf("v%0d err", idx), int'(m_if.err), e.err);
                end
                break;
            end
            if (v.done_at < 0 && j == v.abort_at + 1) break;
            @(negedge clk);
        end
        m_if.start = 1'b0;
        m_if.abort = 1'b0;
        if (v.done_at >= 0) begin
            chk($sformatf("v%0d done_seen", idx), int'(seen), 1);
            @(negedge clk);
            chk($sformatf("v%0d done_one_cycle", idx), int'(m_if.done), 0);
            chk($sformatf("v%0d idle_after_done", idx), int'(m_if.busy), 0);
        end else begin
            chk($sformatf("v%0d no_done", idx), int'(seen), 0);
            chk($sformatf("v%0d no_outporten", idx), int'(oen), 0);
            chk($sformatf("v%0d busy_after_abort", idx), int'(m_if.busy), 0);
            chk($sformatf("v%0d iter_held", idx), int'(m_if.iter_cnt), v.exp_iter);
            chk($sformatf("v%0d err_held", idx), int'(m_if.err), v.exp_err);
            chk($sformatf("v%0d outport_kept", idx), int'(m_out), v.exp_out);
        end
    endtask
    initial begin
        bit seen;
        bit oen;
        vecs[0] = '{-1, -1, 36, 11, 0, 55};
        vecs[1] = '{-1, 10, 36, 11, 0, 55};
        vecs[2] = '{14, -1, -1,  4, 0, 55};
        vecs[3] = '{ 0, -1, -1,  4, 0, 55};
        vecs[4] = '{-1, -1, 36, 11, 0, 55};
        m_if.start = 1'b0; m_if.abort = 1'b0;
        w_if.start = 1'b0; w_if.abort = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl_zero", m_ctrl(), 0);
        chk("reset_iter_zero", int'(m_if.iter_cnt), 0);
        reset = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", m_ctrl(), 0);
        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);
        m_if.start = 1'b1;
        m_if.abort = 1'b1;
        @(negedge clk);
        m_if.start = 1'b0;
        m_if.abort = 1'b0;
        chk("start_abort_idle", m_ctrl() & ~1, 0);
        @(negedge clk);
        chk("start_abort_still_idle", int'(m_if.busy), 0);
        w_if.start = 1'b1;
        @(negedge clk);
        w_if.start = 1'b0;
        seen = 0;
        oen = 0;
        for (int j = 0; j < 40 && !seen; j++) begin
            if (w_if.OutPortEn) oen = 1;
            if (w_if.done) begin
                seen = 1;
                chk("wd_done_cycle", j, 17);
                chk("wd_err", int'(w_if.err), 1);
                chk("wd_iter", int'(w_if.iter_cnt), 5);
                chk("wd_outport_kept", int'(w_out), 0);
            end else @(negedge clk);
        end
        chk("wd_done_seen", int'(seen), 1);
        chk("wd_no_outporten", int'(oen), 0);
        @(negedge clk);
        chk("wd_err_sticky_idle", int'(w_if.err), 1);
        w_if.start = 1'b1;
        @(negedge clk);
        w_if.start = 1'b0;
        @(negedge clk);
        chk("wd_restart_err_clear", int'(w_if.err), 0);
        chk("wd_restart_iter_clear", int'(w_if.iter_cnt), 0);
        seen = 0;
        for (int j = 0; j < 40 && !seen; j++) begin
            if (w_if.done) seen = 1;
            else @(negedge clk);
        end
        chk("wd_second_done", int'(seen), 1);
        m_if.start = 1'b1;
        @(negedge clk);
        m_if.start = 1'b0;
        repeat (20) @(negedge clk);
        chk("midrun_busy", int'(m_if.busy), 1);
        chk("midrun_iter", int'(m_if.iter_cnt), 6);
        reset = 1'b0;
        #1;
        chk("async_reset_ctrl", m_ctrl(), 0);
        chk("async_reset_iter", int'(m_if.iter_cnt), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("after_reset_idle", int'(m_if.busy), 0);
        run_vec(vecs[0], 5);
        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
